rs_issue_scheduler: RTL and testbench
=====================================

// Module: rs_issue_scheduler
// PURPOSE
//  Issue scheduler between the reservation station array and the ALU lanes.
//  - Each cycle, picks up to NUM_ALU ready RS entries that have not yet issued.
//  - Priority is oldest-first by ROB age.
//  - Holds each pick in a per-lane issue register until that ALU accepts it.
//  - Tracks which entries are in flight, so none is issued twice before the RS frees it.
// PARAMETERS
//  SIZE      8  number of reservation station entries
//  ROB_SIZE  8  ROB depth; tags are ROB indices, modulo ROB_SIZE
//  NUM_ALU   2  number of ALU issue lanes
//  TAG_W     4  ROB tag width (matches 4-bit tag used in rs_t)
//  IDX_W     $clog2(SIZE)  RS entry index width
// PORTS
//  clk          in   1               rising-edge clock
//  rst          in   1               asynchronous, active-low reset
//  flush        in   1               synchronous pipeline flush (mispredict)
//  rs_ready     in   SIZE            per-entry: valid and both operands resolved
//  rs_tag       in   SIZE x TAG_W    per-entry ROB tag
//  rs_clear     in   SIZE            per-entry: RS is freeing the entry this cycle (ALU broadcast)
//  rob_head     in   TAG_W           tag of oldest ROB entry
//  alu_ready    in   NUM_ALU         lane's ALU accepts an issue this cycle
//  issue_valid  out  NUM_ALU         lane holds a valid issue
//  issue_idx    out  NUM_ALU x IDX_W RS entry index for the lane
//  issue_tag    out  NUM_ALU x TAG_W ROB tag for the lane
//  issued_mask  out  SIZE            entries currently issued or in flight
//  num_issued   out  $clog2(SIZE)+1  popcount of issued_mask
// BEHAVIOUR
//  Reset (rst=0, async): issue_valid=0, issue_idx=0, issue_tag=0, issued_mask=0, num_issued=0.
//  Candidates: cand[i] = rs_ready[i] & ~issued_mask[i] & ~rs_clear[i].
//  Age: age[i] = (rs_tag[i] - rob_head) mod ROB_SIZE, computed in TAG_W bits.
//   - Smaller age is older. Ties go to the lower index.
//  Lane freedom: lane l is free when ~issue_valid[l] | alu_ready[l].
//   - A transfer happens when issue_valid[l] & alu_ready[l].
//  Allocation, each cycle:
//   - Free lanes are filled in ascending lane order.
//   - Lane 0 gets the oldest candidate, the next free lane the next-oldest, and so on.
//   - No entry is picked for two lanes in one cycle.
//   - Free lanes with no candidate load issue_valid=0.
//   - Non-free lanes hold idx, tag and valid unchanged (stall).
//  Latency: an entry whose rs_ready rises at edge N appears on issue_valid after edge N+1.
//   - Condition: a lane is free.
//   - Back-to-back: a new pick loads in the same edge a transfer completes.
//  issued_mask[i]:
//   - Set at the edge where entry i is captured into a lane.
//   - Cleared at the edge where rs_clear[i]=1.
//   - Clear has priority over set; cand excludes cleared entries, so no conflict arises.
//   - Stays set after the ALU transfer until rs_clear[i].
//  flush=1: at the next edge, all lanes are invalid and issued_mask=0.
//   - Overrides allocation and alu_ready in that cycle.
//   - No issue is presented the cycle after flush.
//  rs_ready deasserting for a captured entry does not retract the lane.
//   - The RS must not change a captured entry before rs_clear.
//  All ready entries already issued, or no ready entries: lanes drain; no spurious issue_valid.
//  ROB wrap: rob_head=6, tags 7 and 1 -> ages 1 and 3; tag 7 is older.
//  num_issued is combinational popcount of the issued_mask register.
// STRUCTURE
//  rv32i_types additions:
//   - typedef issue_t {logic valid; logic [IDX_W-1:0] idx; logic [TAG_W-1:0] tag;}
//   - localparam ROB_TAG_W = 4.
//  Sub-module age_select:
//   - Combinational; takes a candidate mask and per-entry ages.
//   - Returns the oldest index plus a found flag.
//   - Instantiated NUM_ALU times in a chain; each stage masks out earlier picks.
//  Top level holds the lane registers, issued_mask and flush/reset logic.
// TESTING
//  1 Reset release, rs_ready=0 -> issue_valid=00, issued_mask=0 indefinitely.
//  2 rob_head=6; entries 2 (tag 1), 5 (tag 7), 0 (tag 3) ready; alu_ready=11.
//    -> lane0 idx5/tag7, lane1 idx2/tag1; next cycle lane0 idx0/tag3; issued_mask={0,2,5}.
//  3 Lane0 valid idx3, alu_ready=01 for 3 cycles.
//    -> lane0 refills each cycle; lane1 holds its value unchanged while alu_ready[1]=0.
//  4 Entry 4 issued, then rs_clear[4] with rs_ready[4] still 1 in the same cycle.
//    -> entry 4 not reissued that cycle; issued_mask[4]=0 next edge.
//  5 flush with both lanes valid and alu_ready=0 -> next cycle issue_valid=00, issued_mask=0.
//  6 Assert rst low mid-stall (asynchronously, between edges).
//    -> outputs zero immediately; after release, ready entries issue oldest-first.

Source files
------------

// File: rtl/rs_issue_scheduler_pkg.sv
// rs_issue_scheduler_pkg: shared sizes, lane record and ROB age helper for the issue scheduler
package rs_issue_scheduler_pkg;
  localparam int SIZE      = 8;
  localparam int ROB_SIZE  = 8;
  localparam int NUM_ALU   = 2;
  localparam int ROB_TAG_W = 4;
  localparam int TAG_W     = ROB_TAG_W;
  localparam int IDX_W     = $clog2(SIZE);
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
  } issue_t;
  function automatic logic [TAG_W-1:0] rob_age(input logic [TAG_W-1:0] tag, input logic [TAG_W-1:0] head);
    logic [TAG_W-1:0] d;
    d = tag - head;
    return d % TAG_W'(ROB_SIZE);
  endfunction
endpackage

// File: rtl/rs_issue_scheduler_age_select.sv
// rs_issue_scheduler_age_select: picks the oldest candidate entry, lower index wins ties
module rs_issue_scheduler_age_select
  import rs_issue_scheduler_pkg::*;
(
  input  logic [SIZE-1:0]            cand,
  input  logic [SIZE-1:0][TAG_W-1:0] age,
  output logic [IDX_W-1:0]           idx,
  output logic                       found
);
  logic [TAG_W-1:0] best;
  always_comb begin
    found = 1'b0;
    idx   = '0;
    best  = '0;
    for (int i = 0; i < SIZE; i++)
      if (cand[i] && (!found || age[i] < best)) begin
        found = 1'b1;
        idx   = IDX_W'(i);
        best  = age[i];
      end
  end
endmodule

// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: oldest-first issue of ready RS entries into per-lane issue registers,
// tracking in-flight entries until the RS frees them
module rs_issue_scheduler
  import rs_issue_scheduler_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [SIZE-1:0]              rs_ready,
  input  logic [SIZE-1:0][TAG_W-1:0]   rs_tag,
  input  logic [SIZE-1:0]              rs_clear,
  input  logic [TAG_W-1:0]             rob_head,
  input  logic [NUM_ALU-1:0]           alu_ready,
  output logic [NUM_ALU-1:0]           issue_valid,
  output logic [NUM_ALU-1:0][IDX_W-1:0] issue_idx,
  output logic [NUM_ALU-1:0][TAG_W-1:0] issue_tag,
  output logic [SIZE-1:0]              issued_mask,
  output logic [IDX_W:0]               num_issued
);
  logic [SIZE-1:0]            issued_q, cand, picked;
  logic [SIZE-1:0][TAG_W-1:0] age;
  always_comb begin
    cand = rs_ready & ~issued_q & ~rs_clear;
    for (int i = 0; i < SIZE; i++) age[i] = rob_age(rs_tag[i], rob_head);
  end
  // Each stage sees only what earlier free lanes left behind; stalled lanes consume nothing
  for (genvar l = 0; l < NUM_ALU; l++) begin : g_lane
    logic [SIZE-1:0]  in_mask, out_mask;
    logic [IDX_W-1:0] pick;
    logic             found, free;
    issue_t           q;
    if (l == 0) begin : g_first
      assign in_mask = cand;
    end else begin : g_next
      assign in_mask = g_lane[l-1].out_mask;
    end
    rs_issue_scheduler_age_select u_sel (
      .cand  (in_mask),
      .age   (age),
      .idx   (pick),
      .found (found)
    );
    assign free     = ~q.valid | alu_ready[l];
    assign out_mask = in_mask & ~((free && found) ? SIZE'(1) << pick : '0);
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (flush) q <= '0;
      else if (free) q <= found ? issue_t'{valid: 1'b1, idx: pick, tag: rs_tag[pick]} : '0;
    assign issue_valid[l] = q.valid;
    assign issue_idx[l]   = q.idx;
    assign issue_tag[l]   = q.tag;
  end
  assign picked = cand & ~g_lane[NUM_ALU-1].out_mask;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) issued_q <= '0;
    else if (flush) issued_q <= '0;
    else issued_q <= (issued_q | picked) & ~rs_clear;
  assign issued_mask = issued_q;
  assign num_issued  = (IDX_W+1)'($countones(issued_q));
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler: directed and random stimulus, sorted-candidate reference model, scoreboard monitor
module tb_rs_issue_scheduler;
  import rs_issue_scheduler_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [SIZE-1:0]               rs_ready = '0, rs_clear = '0;
  logic [SIZE-1:0][TAG_W-1:0]    rs_tag = '0;
  logic [TAG_W-1:0]              rob_head = '0;
  logic [NUM_ALU-1:0]            alu_ready = '0;
  logic [NUM_ALU-1:0]            issue_valid;
  logic [NUM_ALU-1:0][IDX_W-1:0] issue_idx;
  logic [NUM_ALU-1:0][TAG_W-1:0] issue_tag;
  logic [SIZE-1:0]               issued_mask;
  logic [IDX_W:0]                num_issued;

  rs_issue_scheduler dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .rs_ready(rs_ready), .rs_tag(rs_tag),
    .rs_clear(rs_clear), .rob_head(rob_head), .alu_ready(alu_ready),
    .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_tag(issue_tag),
    .issued_mask(issued_mask), .num_issued(num_issued)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_ALU-1:0]            v;
    logic [NUM_ALU-1:0][IDX_W-1:0] idx;
    logic [NUM_ALU-1:0][TAG_W-1:0] tag;
    logic [SIZE-1:0]               mask;
    int                            num;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;

  bit              mv[NUM_ALU];
  int              mi[NUM_ALU], mt[NUM_ALU];
  logic [SIZE-1:0] mmask = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int l = 0; l < NUM_ALU; l++) begin mv[l] = 0; mi[l] = 0; mt[l] = 0; end
    mmask = '0;
  endfunction

  // Candidates sorted by (age, index); free lanes take them in lane order
  function automatic void model_step();
    int q[$];
    int k;
    logic [SIZE-1:0] nm;
    if (!rst_n) begin model_reset(); return; end
    if (flush) begin
      for (int l = 0; l < NUM_ALU; l++) mv[l] = 0;
      mmask = '0;
      return;
    end
    for (int i = 0; i < SIZE; i++)
      if (rs_ready[i] && !mmask[i] && !rs_clear[i])
        q.push_back((((int'(rs_tag[i]) - int'(rob_head)) % ROB_SIZE + ROB_SIZE) % ROB_SIZE) * SIZE + i);
    q.sort();
    nm = mmask;
    for (int l = 0; l < NUM_ALU; l++)
      if (!mv[l] || alu_ready[l]) begin
        if (q.size() > 0) begin
          k = q.pop_front();
          mv[l] = 1; mi[l] = k % SIZE; mt[l] = int'(rs_tag[k % SIZE]);
          nm[k % SIZE] = 1'b1;
        end else mv[l] = 0;
      end
    mmask = nm & ~rs_clear;
  endfunction

  task automatic cycle();
    exp_t e;
    model_step();
    for (int l = 0; l < NUM_ALU; l++) begin
      e.v[l] = mv[l]; e.idx[l] = IDX_W'(mi[l]); e.tag[l] = TAG_W'(mt[l]);
    end
    e.mask = mmask;
    e.num  = $countones(mmask);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  exp_t m;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      m = sb.pop_front();
      check("issue_valid", int'(issue_valid), int'(m.v));
      check("issued_mask", int'(issued_mask), int'(m.mask));
      check("num_issued", int'(num_issued), m.num);
      for (int l = 0; l < NUM_ALU; l++)
        if (m.v[l]) begin
          check($sformatf("lane%0d_idx", l), int'(issue_idx[l]), int'(m.idx[l]));
          check($sformatf("lane%0d_tag", l), int'(issue_tag[l]), int'(m.tag[l]));
        end
    end
  end

  bit ent_v[SIZE], ent_rdy[SIZE];
  int ent_tag[SIZE];
  bit inl;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", int'(issue_valid), 0);
    check("rst_idx", int'(issue_idx), 0);
    check("rst_tag", int'(issue_tag), 0);
    check("rst_mask", int'(issued_mask), 0);
    check("rst_num", int'(num_issued), 0);
    rst_n = 1'b1;
    alu_ready = 2'b11;
    repeat (4) cycle();
    // ROB wrap ordering
    rob_head = 4'd6;
    rs_tag[2] = 4'd1; rs_tag[5] = 4'd7; rs_tag[0] = 4'd3;
    rs_ready = 8'b0010_0101;
    cycle();
    check("wrap_l0_idx", int'(issue_idx[0]), 5);
    check("wrap_l0_tag", int'(issue_tag[0]), 7);
    check("wrap_l1_idx", int'(issue_idx[1]), 2);
    check("wrap_l1_tag", int'(issue_tag[1]), 1);
    cycle();
    check("wrap2_valid", int'(issue_valid), 1);
    check("wrap2_l0_idx", int'(issue_idx[0]), 0);
    check("wrap2_mask", int'(issued_mask), 8'b0010_0101);
    rs_clear = 8'b0010_0101;
    cycle();
    rs_clear = '0; rs_ready = '0;
    cycle();
    // lane 1 stalls while lane 0 refills
    rob_head = 4'd0;
    rs_tag[3] = 4'd0; rs_tag[1] = 4'd1; rs_tag[6] = 4'd2; rs_tag[7] = 4'd3; rs_tag[4] = 4'd4;
    rs_ready = 8'b1101_1010;
    cycle();
    check("stall_l0_idx", int'(issue_idx[0]), 3);
    alu_ready = 2'b01;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("stall_l1_valid", int'(issue_valid[1]), 1);
      check("stall_l1_idx", int'(issue_idx[1]), 1);
    end
    // clear while still ready: no reissue, mask drops
    alu_ready = 2'b11;
    rs_clear = 8'b1101_1010;
    cycle();
    check("clr_valid", int'(issue_valid), 0);
    check("clr_mask", int'(issued_mask), 0);
    rs_clear = '0; rs_ready = '0;
    cycle();
    // flush with both lanes stalled
    rob_head = 4'd5;
    rs_tag[0] = 4'd5; rs_tag[2] = 4'd6;
    rs_ready = 8'b0000_0101;
    cycle();
    alu_ready = 2'b00; flush = 1'b1;
    cycle();
    check("flush_valid", int'(issue_valid), 0);
    check("flush_mask", int'(issued_mask), 0);
    flush = 1'b0;
    repeat (2) cycle();
    // asynchronous reset mid-stall
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(issue_valid), 0);
    check("arst_mask", int'(issued_mask), 0);
    check("arst_num", int'(num_issued), 0);
    model_reset();
    cycle();
    rst_n = 1'b1; alu_ready = 2'b11;
    cycle();
    check("arst_l0_idx", int'(issue_idx[0]), 0);
    check("arst_l1_idx", int'(issue_idx[1]), 2);
    rs_clear = 8'b0000_0101;
    cycle();
    rs_clear = '0; rs_ready = '0;
    cycle();
    // random traffic from a small RS model
    for (int i = 0; i < SIZE; i++) begin ent_v[i] = 0; ent_rdy[i] = 0; ent_tag[i] = 0; end
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < SIZE; i++) if (rs_clear[i]) ent_v[i] = 0;
      rs_clear = '0;
      for (int i = 0; i < SIZE; i++) begin
        if (!ent_v[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            ent_v[i] = 1; ent_rdy[i] = 0; ent_tag[i] = int'($urandom_range(0, 7));
          end
        end else if (!ent_rdy[i]) ent_rdy[i] = ($urandom_range(0, 2) == 0);
        else if (mmask[i]) begin
          inl = 0;
          for (int l = 0; l < NUM_ALU; l++) if (mv[l] && mi[l] == i) inl = 1;
          if (!inl && $urandom_range(0, 2) == 0) rs_clear[i] = 1'b1;
        end
        rs_ready[i] = ent_v[i] & ent_rdy[i];
        rs_tag[i]   = TAG_W'(ent_tag[i]);
      end
      alu_ready = NUM_ALU'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) rob_head = TAG_W'($urandom_range(0, 7));
      flush = ($urandom_range(0, 49) == 0);
      cycle();
    end
    flush = 1'b0;
    @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
